// File: rtl/ysyx_25060170_pkg.sv
// Shared LSU types: memory op codes, FSM state, store/align helpers.
// Imported by ysyx_25060170_lsu and ysyx_25060170_lsu_ext.
package ysyx_25060170_pkg;

    typedef enum logic [3:0] {
        MEM_NONE = 4'd0,
        LB       = 4'd1,
        LH       = 4'd2,
        LW       = 4'd3,
        LBU      = 4'd4,
        LHU      = 4'd5,
        SB       = 4'd6,
        SH       = 4'd7,
        SW       = 4'd8
    } mem_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } lsu_state_t;

    function automatic logic is_store(input mem_op_t op);
        return op inside {SB, SH, SW};
    endfunction

    function automatic logic is_load(input mem_op_t op);
        return op inside {LB, LH, LW, LBU, LHU};
    endfunction

    function automatic logic misaligned(
        input mem_op_t    op,
        input logic [1:0] off
    );
        logic m;
        m = 1'b0;
        case (op)
            LH, LHU, SH: m = off[0];
            LW, SW:      m = |off;
            default:     m = 1'b0;
        endcase
        return m;
    endfunction

    function automatic logic [3:0] st_strb(
        input mem_op_t    op,
        input logic [1:0] off
    );
        logic [3:0] s;
        s = 4'b0000;
        case (op)
            SB:      s = 4'b0001 << off;
            SH:      s = 4'b0011 << {off[1], 1'b0};
            SW:      s = 4'b1111;
            default: s = 4'b0000;
        endcase
        return s;
    endfunction

    // Byte/half replicated on every lane so the strobe alone picks the target.
    function automatic logic [31:0] st_wdata(
        input mem_op_t     op,
        input logic [31:0] w
    );
        logic [31:0] d;
        d = w;
        case (op)
            SB:      d = {4{w[7:0]}};
            SH:      d = {2{w[15:0]}};
            default: d = w;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/ysyx_25060170_lsu_ext.sv
// Load lane select and sign/zero extension (combinational).
// Ports: op_i, off_i (addr[1:0]), rdata_i (read word) -> data_o.
module ysyx_25060170_lsu_ext
    import ysyx_25060170_pkg::*;
(
    input  mem_op_t     op_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    always_comb begin
        byte_s = 8'h00;
        case (off_i)
            2'd0:    byte_s = rdata_i[7:0];
            2'd1:    byte_s = rdata_i[15:8];
            2'd2:    byte_s = rdata_i[23:16];
            default: byte_s = rdata_i[31:24];
        endcase
        half_s = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    end

    always_comb begin
        data_o = 32'h0;
        case (op_i)
            LB:      data_o = {{24{byte_s[7]}}, byte_s};
            LBU:     data_o = {24'h0, byte_s};
            LH:      data_o = {{16{half_s[15]}}, half_s};
            LHU:     data_o = {16'h0, half_s};
            LW:      data_o = rdata_i;
            default: data_o = 32'h0;
        endcase
    end

endmodule

// File: rtl/ysyx_25060170_lsu.sv
// Load/store unit between EXU and WBU: IDLE/REQ/WAIT/HOLD FSM driving
// a req/gnt + rvalid memory port. Ports: in_* (EXU side, valid/ready),
// out_* (WBU side, valid/ready), mem_* (memory), err (misalign flag).
// YSYX_25060170_LSU_MISALIGN_CHK_EN: trap misaligned ops with err=1
// instead of issuing them with the aligned-down address.
module ysyx_25060170_lsu
    import ysyx_25060170_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  mem_op_t           in_mem_op,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [DATA_W-1:0] in_wdata,
    input  logic [4:0]        in_rd,
    input  logic              in_rwen,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_wdata,
    output logic [4:0]        out_rd,
    output logic              out_rwen,
    output logic              mem_req,
    input  logic              mem_gnt,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [3:0]        mem_wstrb,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              err
);

    lsu_state_t        state_q;
    mem_op_t           op_q;
    logic [1:0]        off_q;
    logic              in_ready_q;
    logic              out_valid_q;
    logic [DATA_W-1:0] out_wdata_q;
    logic [4:0]        out_rd_q;
    logic              out_rwen_q;
    logic              mem_req_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic [3:0]        mem_wstrb_q;
    logic              err_q;
    logic              mis;
    logic              accept;
    logic              rd_wen;
    logic [DATA_W-1:0] ld_data;

`ifdef YSYX_25060170_LSU_MISALIGN_CHK_EN
    assign mis = misaligned(in_mem_op, in_addr[1:0]);
`else
    assign mis = 1'b0;
`endif

    assign accept = in_valid && in_ready_q;
    assign rd_wen = in_rwen && (in_rd != 5'd0);

    ysyx_25060170_lsu_ext u_ext (
        .op_i    (op_q),
        .off_i   (off_q),
        .rdata_i (mem_rdata),
        .data_o  (ld_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            op_q        <= MEM_NONE;
            off_q       <= 2'b00;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_wdata_q <= '0;
            out_rd_q    <= 5'd0;
            out_rwen_q  <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= 4'b0000;
            err_q       <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    in_ready_q <= 1'b1;
                    if (accept) begin
                        in_ready_q <= 1'b0;
                        op_q       <= in_mem_op;
                        off_q      <= in_addr[1:0];
                        out_rd_q   <= in_rd;
                        if (in_mem_op == MEM_NONE) begin
                            out_wdata_q <= in_addr;
                            out_rwen_q  <= rd_wen;
                            out_valid_q <= 1'b1;
                            state_q     <= HOLD;
                        end else if (mis) begin
                            out_wdata_q <= '0;
                            out_rwen_q  <= 1'b0;
                            err_q       <= 1'b1;
                            out_valid_q <= 1'b1;
                            state_q     <= HOLD;
                        end else begin
                            out_rwen_q  <= rd_wen
                                && !is_store(in_mem_op);
                            mem_req_q   <= 1'b1;
                            mem_we_q    <= is_store(in_mem_op);
                            mem_addr_q  <= {in_addr[ADDR_W-1:2], 2'b00};
                            mem_wdata_q <= st_wdata(in_mem_op, in_wdata);
                            mem_wstrb_q <= st_strb(in_mem_op, in_addr[1:0]);
                            state_q     <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (mem_gnt) begin
                        mem_req_q <= 1'b0;
                        state_q   <= WAIT;
                    end
                end
                WAIT: begin
                    if (mem_rvalid) begin
                        out_wdata_q <= is_load(op_q) ? ld_data : '0;
                        out_valid_q <= 1'b1;
                        state_q     <= HOLD;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        err_q       <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_wdata = out_wdata_q;
    assign out_rd    = out_rd_q;
    assign out_rwen  = out_rwen_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wstrb = mem_wstrb_q;
    assign err       = err_q;

endmodule

// File: tb/tb_ysyx_25060170_lsu.sv
// Self-checking bench for ysyx_25060170_lsu: directed scenarios then
// randomized ops against a behavioural reference model.
module tb_ysyx_25060170_lsu;
    import ysyx_25060170_pkg::*;

`ifdef YSYX_25060170_LSU_MISALIGN_CHK_EN
    localparam bit MIS_EN = 1'b1;
`else
    localparam bit MIS_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    mem_op_t     in_mem_op;
    logic [31:0] in_addr;
    logic [31:0] in_wdata;
    logic [4:0]  in_rd;
    logic        in_rwen;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_wdata;
    logic [4:0]  out_rd;
    logic        out_rwen;
    logic        mem_req;
    logic        mem_gnt;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ysyx_25060170_lsu #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_mem_op  (in_mem_op),
        .in_addr    (in_addr),
        .in_wdata   (in_wdata),
        .in_rd      (in_rd),
        .in_rwen    (in_rwen),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_wdata  (out_wdata),
        .out_rd     (out_rd),
        .out_rwen   (out_rwen),
        .mem_req    (mem_req),
        .mem_gnt    (mem_gnt),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wstrb  (mem_wstrb),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .err        (err)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference model, arithmetic form of the load/store rules.
    function automatic logic [31:0] m_load(input mem_op_t op,
                                           input logic [31:0] a,
                                           input logic [31:0] w);
        logic [31:0] v;
        v = 32'h0;
        case (op)
            LB, LBU: begin
                v = (w >> (8 * (a % 4))) & 32'hFF;
                if (op == LB && v >= 32'd128) v = v + 32'hFFFF_FF00;
            end
            LH, LHU: begin
                v = (w >> (16 * ((a % 4) / 2))) & 32'hFFFF;
                if (op == LH && v >= 32'd32768) v = v + 32'hFFFF_0000;
            end
            LW: v = w;
            default: v = 32'h0;
        endcase
        return v;
    endfunction

    function automatic logic [3:0] m_strb(input mem_op_t op,
                                          input logic [31:0] a);
        int unsigned s;
        s = 0;
        case (op)
            SB: s = 1 << (a % 4);
            SH: s = ((a % 4) >= 2) ? 12 : 3;
            SW: s = 15;
            default: s = 0;
        endcase
        return 4'(s);
    endfunction

    function automatic logic [31:0] m_wdata(input mem_op_t op,
                                            input logic [31:0] w);
        logic [31:0] d;
        d = w;
        case (op)
            SB: d = (w & 32'hFF) * 32'h0101_0101;
            SH: d = (w & 32'hFFFF) * 32'h0001_0001;
            default: d = w;
        endcase
        return d;
    endfunction

    function automatic bit m_mis(input mem_op_t op, input logic [31:0] a);
        if (op == LH || op == LHU || op == SH) return (a % 2) != 0;
        if (op == LW || op == SW) return (a % 4) != 0;
        return 1'b0;
    endfunction

    task automatic run_op(input string tag, input mem_op_t op,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input logic [4:0] rd, input logic rwen,
                          input logic [31:0] rdata, input int gdly,
                          input int rdly);
        bit st;
        bit ld;
        bit mis;
        logic [31:0] exp_out;
        logic [31:0] held;
        logic        exp_rwen;
        st  = op inside {SB, SH, SW};
        ld  = op inside {LB, LH, LW, LBU, LHU};
        mis = MIS_EN && m_mis(op, addr);
        exp_rwen = rwen && (rd != 0) && !st && !mis;
        exp_out  = (op == MEM_NONE) ? addr : m_load(op, addr, rdata);

        @(negedge clk);
        chk({tag, "/in_ready"}, in_ready, 1);
        in_valid  = 1'b1;
        in_mem_op = op;
        in_addr   = addr;
        in_wdata  = wd;
        in_rd     = rd;
        in_rwen   = rwen;
        @(negedge clk);
        in_valid  = 1'b0;
        in_mem_op = MEM_NONE;
        in_addr   = $urandom;
        chk({tag, "/busy"}, in_ready, 0);

        if (op == MEM_NONE || mis) begin
            chk({tag, "/no_req"}, mem_req, 0);
        end else begin
            chk({tag, "/req"}, mem_req, 1);
            chk({tag, "/addr"}, mem_addr, addr - (addr % 4));
            chk({tag, "/we"}, mem_we, st);
            if (st) begin
                chk({tag, "/strb"}, mem_wstrb, m_strb(op, addr));
                chk({tag, "/wdata"}, mem_wdata, m_wdata(op, wd));
            end
            for (int i = 0; i < gdly; i++) begin
                mem_rvalid = 1'($urandom % 2);
                mem_rdata  = $urandom;
                @(negedge clk);
                chk({tag, "/req_hold"}, mem_req, 1);
                chk({tag, "/addr_hold"}, mem_addr, addr - (addr % 4));
                chk({tag, "/busy_req"}, in_ready, 0);
                chk({tag, "/ov_req"}, out_valid, 0);
            end
            mem_rvalid = 1'b0;
            mem_gnt    = 1'b1;
            @(negedge clk);
            mem_gnt = 1'b0;
            chk({tag, "/req_drop"}, mem_req, 0);
            chk({tag, "/ov_wait"}, out_valid, 0);
            mem_rvalid = 1'b1;
            mem_rdata  = rdata;
            @(negedge clk);
            mem_rvalid = 1'b0;
            mem_rdata  = $urandom;
        end

        chk({tag, "/out_valid"}, out_valid, 1);
        chk({tag, "/err"}, err, mis);
        chk({tag, "/out_rd"}, out_rd, rd);
        chk({tag, "/out_rwen"}, out_rwen, exp_rwen);
        if (op == MEM_NONE || (ld && !mis))
            chk({tag, "/out_wdata"}, out_wdata, exp_out);
        held = out_wdata;
        for (int i = 0; i < rdly; i++) begin
            @(negedge clk);
            chk({tag, "/ov_hold"}, out_valid, 1);
            chk({tag, "/wd_hold"}, out_wdata, held);
            chk({tag, "/rd_hold"}, out_rd, rd);
            chk({tag, "/busy_hold"}, in_ready, 0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "/ov_drop"}, out_valid, 0);
        chk({tag, "/err_drop"}, err, 0);
    endtask

    initial begin
        mem_op_t ops [9];
        mem_op_t op;
        logic [31:0] a;
        ops = '{MEM_NONE, LB, LH, LW, LBU, LHU, SB, SH, SW};
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_mem_op  = MEM_NONE;
        in_addr    = 32'h0;
        in_wdata   = 32'h0;
        in_rd      = 5'd0;
        in_rwen    = 1'b0;
        out_ready  = 1'b0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;

        repeat (2) @(negedge clk);
        chk("rst/in_ready", in_ready, 0);
        chk("rst/out_valid", out_valid, 0);
        chk("rst/mem_req", mem_req, 0);
        chk("rst/err", err, 0);
        chk("rst/out_wdata", out_wdata, 0);
        chk("rst/mem_addr", mem_addr, 0);
        chk("rst/mem_wstrb", mem_wstrb, 0);
        rst_n = 1'b1;

        run_op("pass", MEM_NONE, 32'h1234, 32'h0, 5'd5, 1'b1,
               32'h0, 0, 0);
        run_op("lb", LB, 32'h8000_0003, 32'h0, 5'd7, 1'b1,
               32'h80FF_0000, 0, 0);
        run_op("sh", SH, 32'h8000_0002, 32'h0000_ABCD, 5'd3, 1'b1,
               32'h0, 0, 0);
        run_op("bp", LW, 32'h8000_0010, 32'h0, 5'd9, 1'b1,
               32'hDEAD_BEEF, 3, 2);
        run_op("mis", LW, 32'h8000_0001, 32'h0, 5'd4, 1'b1,
               32'h1357_9BDF, 0, 0);
        run_op("rd0", LW, 32'h8000_0020, 32'h0, 5'd0, 1'b1,
               32'h5555_AAAA, 1, 1);

        // Reset while waiting for read data, then a stale rvalid.
        @(negedge clk);
        in_valid  = 1'b1;
        in_mem_op = LW;
        in_addr   = 32'h8000_0040;
        in_rd     = 5'd1;
        in_rwen   = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        mem_gnt  = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        chk("rw/in_wait", mem_req, 0);
        rst_n = 1'b0;
        #1;
        chk("rw/ov", out_valid, 0);
        chk("rw/ready", in_ready, 0);
        @(negedge clk);
        rst_n      = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hFFFF_FFFF;
        @(negedge clk);
        mem_rvalid = 1'b0;
        chk("rw/late_rvalid", out_valid, 0);
        chk("rw/idle", in_ready, 1);
        @(negedge clk);
        chk("rw/still_idle", out_valid, 0);

        for (int n = 0; n < 150; n++) begin
            op = ops[$urandom % 9];
            a  = $urandom;
            if ($urandom % 2 == 0) a = a & 32'hFFFF_FFFC;
            run_op("rand", op, a, $urandom, 5'($urandom),
                   1'($urandom), $urandom, int'($urandom % 4),
                   int'($urandom % 3));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
